// File: rtl/fpu_exc_unit.sv
// fpu_exc_unit: IEEE-754 exception flags for completed FPU operations,
// with a sticky fflags accumulator and per-flag saturating counters.
package mypkg;
  typedef enum logic [3:0] {
    FADD   = 4'd0,
    FSUB   = 4'd1,
    FMUL   = 4'd2,
    FDIV   = 4'd3,
    FSQURT = 4'd4,
    FMADD  = 4'd5,
    FMSUB  = 4'd6,
    FNMADD = 4'd7,
    FNMSUB = 4'd8
  } fpu_op_e;

  typedef struct packed {
    logic sgn;
    logic zero;
    logic inf;
    logic snan;
    logic nan;
  } fp_cls_t;
endpackage

module fpu_exc_unit
  import mypkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  fpu_op_e                opcode_i,
  input  logic [EXP_W+MAN_W:0]   op_a_i,
  input  logic [EXP_W+MAN_W:0]   op_b_i,
  input  logic [EXP_W+MAN_W:0]   op_c_i,
  input  logic [EXP_W+MAN_W:0]   result_i,
  input  logic [2:0]             grs_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [4:0]             flags_o,
  output logic [4:0]             fflags_o,
  input  logic                   fflags_we_i,
  input  logic [4:0]             fflags_wdata_i,
  input  logic                   cnt_clr_i,
  output logic [5*CNT_W-1:0]     cnt_o
);
  localparam int W = 1 + EXP_W + MAN_W;

  function automatic fp_cls_t classify(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    fp_cls_t          c;
    e      = x[W-2 -: EXP_W];
    m      = x[MAN_W-1:0];
    c.sgn  = x[W-1];
    c.zero = (e == '0) && (m == '0);
    c.inf  = (&e) && (m == '0);
    c.nan  = (&e) && (m != '0);
    c.snan = c.nan && !m[MAN_W-1];
    return c;
  endfunction

  fp_cls_t ca, cb, cc, cr;
  logic is_add, is_sub, is_mul, is_div;
  logic is_sqrt, is_fma, is_known;
  logic use_b, use_c, c_neg;
  logic any_snan, any_special, prod_iz;
  logic nv_op, nv, dz, of, nx, uf;
  logic [4:0] new_flags;
  logic accept;

  assign ca = classify(op_a_i);
  assign cb = classify(op_b_i);
  assign cc = classify(op_c_i);
  assign cr = classify(result_i);

  assign is_sub   = opcode_i == FSUB;
  assign is_add   = (opcode_i == FADD) || is_sub;
  assign is_mul   = opcode_i == FMUL;
  assign is_div   = opcode_i == FDIV;
  assign is_sqrt  = opcode_i == FSQURT;
  assign is_fma   = (opcode_i == FMADD) || (opcode_i == FMSUB)
                 || (opcode_i == FNMADD) || (opcode_i == FNMSUB);
  assign is_known = is_add || is_mul || is_div || is_sqrt || is_fma;
  assign use_b    = is_add || is_mul || is_div || is_fma;
  assign use_c    = is_fma;

  // Subtracting forms negate the addend before the sign check.
  assign c_neg = cc.sgn ^ ((opcode_i == FMSUB) || (opcode_i == FNMSUB));

  assign any_snan = ca.snan || (use_b && cb.snan) || (use_c && cc.snan);
  assign any_special = ca.inf || ca.nan
                    || (use_b && (cb.inf || cb.nan))
                    || (use_c && (cc.inf || cc.nan));
  assign prod_iz = (ca.inf && cb.zero) || (ca.zero && cb.inf);

  always_comb begin
    nv_op = 1'b0;
    unique case (1'b1)
      is_add:  nv_op = ca.inf && cb.inf && (ca.sgn ^ cb.sgn ^ is_sub);
      is_mul:  nv_op = prod_iz;
      is_div:  nv_op = (ca.zero && cb.zero) || (ca.inf && cb.inf);
      is_sqrt: nv_op = ca.sgn && !ca.zero && !ca.nan;
      is_fma:  nv_op = prod_iz
                    || ((ca.inf || cb.inf) && !ca.zero && !cb.zero
                        && cc.inf && ((ca.sgn ^ cb.sgn) != c_neg));
      default: nv_op = 1'b0;
    endcase
  end

  assign nv = is_known && (any_snan || nv_op);
  assign dz = is_div && cb.zero && !ca.zero && !ca.inf && !ca.nan;
  assign of = is_known && cr.inf && !any_special && !nv && !dz;
  assign nx = is_known && ((|grs_i) || of) && !nv && !dz;
  assign uf = nx && (result_i[W-2 -: EXP_W] == '0);

  assign new_flags  = {nv, dz, of, uf, nx};
  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      flags_o     <= '0;
      fflags_o    <= '0;
    end else begin
      if (accept) begin
        out_valid_o <= 1'b1;
        flags_o     <= new_flags;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
      fflags_o <= (fflags_we_i ? fflags_wdata_i : fflags_o)
                | (accept ? new_flags : 5'b0);
    end
  end

  logic [CNT_W-1:0] cnt_q [5];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (cnt_clr_i)
          cnt_q[i] <= '0;
        else if (accept && new_flags[i] && !(&cnt_q[i]))
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < 5; i++) cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
  end
endmodule

// File: doc/fpu_exc_unit.md
# fpu_exc_unit

Parametrised IEEE-754 exception-flag unit for the FPU back end. Accepts each completed operation (opcode, operands, final rounded result, rounding bits), derives the five flags {NV,DZ,OF,UF,NX} with a valid/ready handshake through one output register, and keeps a sticky CSR-style `fflags` accumulator and per-flag saturating event counters. Sits between the FPU datapath result stage and the CSR/writeback logic.

## Interface
- `EXP_W`, default 8: exponent width.
- `MAN_W`, default 23: stored mantissa width. Operand width W = 1+EXP_W+MAN_W.
- `CNT_W`, default 16: width of each per-flag event counter.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: asynchronous active-low reset.
- `in_valid_i` in 1: input operation valid.
- `in_ready_o` out 1: unit can accept. Equals `!out_valid_o || out_ready_i`.
- `opcode_i` in `fpu_op_e` (mypkg): FADD, FSUB, FMUL, FDIV, FSQURT, FMADD, FMSUB, FNMADD, FNMSUB; any other value is "other".
- `op_a_i`, `op_b_i`, `op_c_i` in W: source operands.
- `result_i` in W: final rounded result.
- `grs_i` in 3: guard/round/sticky bits discarded by rounding.
- `out_valid_o` out 1, `out_ready_i` in 1: output handshake.
- `flags_o` out 5: {NV,DZ,OF,UF,NX} for the held operation.
- `fflags_o` out 5: sticky accumulator.
- `fflags_we_i` in 1, `fflags_wdata_i` in 5: CSR write.
- `cnt_clr_i` in 1: synchronous clear of all counters.
- `cnt_o` out 5*CNT_W: counters packed NV at MSB slice to NX at LSB slice.

## Operation
- Classes per operand: zero (exp=0, man=0), subnormal (exp=0, man≠0), inf (exp all-ones, man=0), sNaN (exp all-ones, man≠0, man MSB=0), qNaN (man MSB=1).
- Used operands: ADD/SUB/MUL/DIV use a, b; FSQURT uses a; FMA ops use a, b, c; "other" uses none and produces all flags 0.
- **NV**:
  - any used operand sNaN;
  - ADD/SUB with a, b both inf and opposite effective signs (b sign inverted for FSUB);
  - MUL with inf×0 in either order;
  - DIV with 0/0 or inf/inf;
  - FSQURT with a sign=1, a not zero and not NaN (−0 is valid);
  - FMA ops with a×b inf×0, or product inf (a or b inf, neither zero) and c inf with a_sign^b_sign ≠ effective c sign. Effective c sign is c_sign for FMADD/FNMADD and ~c_sign for FMSUB/FNMSUB.
  - qNaN operands alone never raise NV.
- **DZ**: FDIV only, b zero, a finite, nonzero and not NaN.
- **OF**: result inf, no used operand inf or NaN, NV=0, DZ=0.
- **NX**: (|grs_i or OF), forced 0 when NV or DZ.
- **UF**: NX and result exponent field = 0 (tininess after rounding).
- Acceptance = `in_valid_i && in_ready_o`. On acceptance, computed flags load into the output register and `out_valid_o` sets. On `out_valid_o && out_ready_i` without a new acceptance, `out_valid_o` clears.
- **fflags next**:
  - CSR write: `fflags_wdata_i | (accepted ? new_flags : 0)`;
  - otherwise: `fflags_o | (accepted ? new_flags : 0)`.
  - An accepted operation is never lost to a simultaneous CSR write.
- **Counters**: on acceptance, each counter whose flag is set increments, saturating at 2^CNT_W−1. `cnt_clr_i` wins over a simultaneous increment (result 0).

## Timing
- Reset (asynchronous, immediate): `out_valid_o`=0, `flags_o`=0, `fflags_o`=0, all counters 0. `in_ready_o`=1 once reset deasserts. Reset mid-transfer discards the held operation.
- Latency: 1 cycle from acceptance to `flags_o`/`out_valid_o`, and to the `fflags_o`/`cnt_o` update.
- Full throughput with `out_ready_i`=1. Back-to-back acceptance is allowed in the cycle the held result drains.
- While `out_valid_o`=1 and `out_ready_i`=0, `flags_o` is stable and `in_ready_o`=0.
- A CSR write alone updates `fflags_o` the next cycle.

## Test plan
- FADD a=0x7F800000, b=0xFF800000, result 0x7FC00000, grs=0 → `flags_o`=5'b10000 one cycle later; `fflags_o`=5'h10.
- FDIV a=0x3F800000, b=0x00000000, result 0x7F800000 → 5'b01000. FDIV a=b=0 → 5'b10000.
- FMUL a=b=0x7F000000, result 0x7F800000, grs=0 → 5'b00101. FMUL result 0x00000001, grs=3'b010 → 5'b00011. FADD a=0x7FC00000 → 5'b00000. FADD a=0x7FA00000 → 5'b10000.
- FMSUB a=0x7F800000, b=0x3F800000, c=0x7F800000 → NV. FMADD with the same operands → no NV.
- Backpressure: accept op1, hold `out_ready_i`=0 for 3 cycles while `in_valid_i`=1 with op2 → `in_ready_o`=0, `flags_o` stable. Raise `out_ready_i` → op2 accepted that cycle and presented next cycle.
- `fflags_we_i` with wdata 5'b00001 in the same cycle as an accepted NV op → `fflags_o`=5'b10001. With CNT_W=2, 5 NV ops → NV counter=3. Assert `cnt_clr_i` with a 6th NV op → 0. Drop `rst_ni` mid-stream → all outputs 0 immediately.
